// File: rtl/btle_rx_pdu_fetch.sv
// -----------------------------------------------------------------------------
// btle_rx_pdu_fetch
//
// Purpose: after each decode_end from btle_rx, reads the decoded PDU out of the
// octet RAM (1-cycle registered read) and presents it as a valid/ready/last
// byte stream. It also latches per-packet status and counts packets that
// arrive while a previous packet is still being unloaded. A small FIFO
// decouples the RAM read latency from downstream stalls.
//
// Optional feature: define BTLE_RX_PDU_FETCH_CRC_FILTER_EN to consume
// crc_ok=0 packets silently. Their status still pulses, but nothing is
// streamed. When the macro is undefined, every packet is streamed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   decode_end            one-cycle pulse: PDU complete in RAM
//   crc_ok, best_phase,   packet info, valid with decode_end
//   payload_length
//   pdu_octet_mem_addr    RAM read address
//   pdu_octet_mem_data    RAM read data, one cycle after the address
//   m_data/m_valid/       output octet stream
//   m_last/m_ready
//   pkt_status_valid      one-cycle pulse after a packet is accepted
//   pkt_crc_ok, pkt_best_phase, pkt_num_octet, pkt_truncated
//                         latched status of the last accepted packet
//   busy                  a packet is being fetched or drained
//   drop_count            saturating count of packets lost to overrun
// -----------------------------------------------------------------------------
module btle_rx_pdu_fetch #(
    parameter int PDU_ADDR_WIDTH           = 6,
    parameter int PAYLOAD_LENGTH_BIT_WIDTH = 7,
    parameter int BEST_PHASE_BIT_WIDTH     = 3,
    parameter int FIFO_DEPTH_LOG2          = 2,
    parameter int DROP_COUNT_BIT_WIDTH     = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                decode_end,
    input  logic                                crc_ok,
    input  logic [BEST_PHASE_BIT_WIDTH-1:0]     best_phase,
    input  logic [PAYLOAD_LENGTH_BIT_WIDTH-1:0] payload_length,
    output logic [PDU_ADDR_WIDTH-1:0]           pdu_octet_mem_addr,
    input  logic [7:0]                          pdu_octet_mem_data,
    output logic [7:0]                          m_data,
    output logic                                m_valid,
    output logic                                m_last,
    input  logic                                m_ready,
    output logic                                pkt_status_valid,
    output logic                                pkt_crc_ok,
    output logic [BEST_PHASE_BIT_WIDTH-1:0]     pkt_best_phase,
    output logic [PDU_ADDR_WIDTH:0]             pkt_num_octet,
    output logic                                pkt_truncated,
    output logic                                busy,
    output logic [DROP_COUNT_BIT_WIDTH-1:0]     drop_count
);

    localparam int MAX_OCTETS = 2 ** PDU_ADDR_WIDTH;
    localparam int DEPTH      = 2 ** FIFO_DEPTH_LOG2;
    localparam int CW         = FIFO_DEPTH_LOG2 + 1;          // occupancy width
    localparam int NW         = PDU_ADDR_WIDTH + 1;           // octet count width
    localparam int LW         = PAYLOAD_LENGTH_BIT_WIDTH + 1; // raw N width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Read side
    logic [PDU_ADDR_WIDTH-1:0]       r_addr;
    logic [NW-1:0]                   r_num;
    logic                            r_rd_pending;
    logic                            r_rd_last;

    // Output FIFO, entries are {last, data}
    logic [8:0]                      r_fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]      r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]      r_rd_ptr;
    logic [CW-1:0]                   r_count;

    // Status
    logic                            r_status_valid;
    logic                            r_crc_ok;
    logic [BEST_PHASE_BIT_WIDTH-1:0] r_best_phase;
    logic                            r_truncated;
    logic [DROP_COUNT_BIT_WIDTH-1:0] r_drop_count;

    logic [LW-1:0]                   w_n_raw;
    logic                            w_n_trunc;
    logic [NW-1:0]                   w_n;
    logic [CW-1:0]                   w_occupancy;
    logic                            w_has_room;
    logic                            w_issue_last;
    logic [8:0]                      w_head;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_accept;
    logic                            w_start;
    logic                            w_issue;
    logic                            w_drop;

    // Octet count: two header octets plus payload, clamped to RAM size.
    assign w_n_raw   = LW'(payload_length) + LW'(2);
    assign w_n_trunc = int'(w_n_raw) > MAX_OCTETS;
    assign w_n       = w_n_trunc ? NW'(MAX_OCTETS) : NW'(w_n_raw);

    // A read is only issued if its data is guaranteed a FIFO slot, so the
    // RAM never has to be stalled mid-read.
    assign w_occupancy  = r_count + CW'(r_rd_pending);
    assign w_has_room   = w_occupancy < CW'(DEPTH);
    assign w_issue_last = (NW'(r_addr) + NW'(1)) == r_num;

    assign w_head = r_fifo_mem[r_rd_ptr];
    assign w_push = r_rd_pending;
    assign w_pop  = (r_count != '0) && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        w_issue      = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (decode_end) begin
                    w_accept = 1'b1;
`ifdef BTLE_RX_PDU_FETCH_CRC_FILTER_EN
                    if (crc_ok) begin
                        w_start      = 1'b1;
                        w_state_next = ST_FETCH;
                    end
`else
                    w_start      = 1'b1;
                    w_state_next = ST_FETCH;
`endif
                end
            end
            ST_FETCH: begin
                w_drop  = decode_end;
                w_issue = w_has_room;
                if (w_has_room && w_issue_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_drop = decode_end;
                if (w_pop && w_head[8]) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Address generation and in-flight read tracking. The address sits at
    // N-1 through DRAIN and only returns to 0 when the packet is finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_num        <= '0;
            r_rd_pending <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            r_rd_pending <= w_issue;
            r_rd_last    <= w_issue && w_issue_last;
            if (w_accept) begin
                r_num <= w_n;
            end
            if (w_start) begin
                r_addr <= '0;
            end else if (w_issue && !w_issue_last) begin
                r_addr <= r_addr + PDU_ADDR_WIDTH'(1);
            end else if (r_state != ST_IDLE && w_state_next == ST_IDLE) begin
                r_addr <= '0;
            end
        end
    end

    // Output FIFO. The head is read combinationally so that data and last
    // stay put while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= {r_rd_last, pdu_octet_mem_data};
                r_wr_ptr             <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Status latch and overrun counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status_valid <= 1'b0;
            r_crc_ok       <= 1'b0;
            r_best_phase   <= '0;
            r_truncated    <= 1'b0;
            r_drop_count   <= '0;
        end else begin
            r_status_valid <= w_accept;
            if (w_accept) begin
                r_crc_ok     <= crc_ok;
                r_best_phase <= best_phase;
                r_truncated  <= w_n_trunc;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + DROP_COUNT_BIT_WIDTH'(1);
            end
        end
    end

    assign pdu_octet_mem_addr = r_addr;
    assign m_valid            = (r_count != '0);
    assign m_data             = w_head[7:0];
    assign m_last             = w_head[8];
    assign pkt_status_valid   = r_status_valid;
    assign pkt_crc_ok         = r_crc_ok;
    assign pkt_best_phase     = r_best_phase;
    assign pkt_num_octet      = r_num;
    assign pkt_truncated      = r_truncated;
    assign busy               = (r_state != ST_IDLE);
    assign drop_count         = r_drop_count;

endmodule

// File: tb/tb_btle_rx_pdu_fetch.sv
// -----------------------------------------------------------------------------
// tb_btle_rx_pdu_fetch
//
// Directed bench for btle_rx_pdu_fetch. A RAM model preloaded with 0x00..0x3F
// feeds the read port. Inputs are driven 1 time unit after the rising edge,
// and outputs are sampled on the falling edge. All expected values are
// hand-derived from the packet parameters.
// -----------------------------------------------------------------------------
module tb_btle_rx_pdu_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       decode_end;
    logic       crc_ok;
    logic [2:0] best_phase;
    logic [6:0] payload_length;
    logic [5:0] pdu_octet_mem_addr;
    logic [7:0] pdu_octet_mem_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       pkt_status_valid;
    logic       pkt_crc_ok;
    logic [2:0] pkt_best_phase;
    logic [6:0] pkt_num_octet;
    logic       pkt_truncated;
    logic       busy;
    logic [7:0] drop_count;

    btle_rx_pdu_fetch dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .decode_end         (decode_end),
        .crc_ok             (crc_ok),
        .best_phase         (best_phase),
        .payload_length     (payload_length),
        .pdu_octet_mem_addr (pdu_octet_mem_addr),
        .pdu_octet_mem_data (pdu_octet_mem_data),
        .m_data             (m_data),
        .m_valid            (m_valid),
        .m_last             (m_last),
        .m_ready            (m_ready),
        .pkt_status_valid   (pkt_status_valid),
        .pkt_crc_ok         (pkt_crc_ok),
        .pkt_best_phase     (pkt_best_phase),
        .pkt_num_octet      (pkt_num_octet),
        .pkt_truncated      (pkt_truncated),
        .busy               (busy),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    // Octet RAM with registered read, preloaded with its own address
    logic [7:0] ram [64];
    always @(posedge clk) pdu_octet_mem_data <= ram[pdu_octet_mem_addr];

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         t_de;
    int         base;
    int         first_valid_cyc;
    int         last_xfer_cyc;
    int         status_cyc;
    int         status_cnt = 0;
    int         max_addr;
    logic [8:0] rx_q[$];
    bit         prev_stall = 1'b0;
    logic [8:0] prev_head;
    bit         rdy_toggle = 1'b0;
    logic       rdy_const = 1'b1;
    logic [3:0] rdy_pat = 4'b1001;   // ready sequence 1,0,0,1
    int         pidx = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: sample at the falling edge, then drive after the
    // rising edge. decode_end is dropped automatically so it is one cycle.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'({m_last, m_data}), 32'(prev_head));
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pkt_status_valid) begin
                status_cyc = cyc;
                status_cnt++;
            end
            if (busy && int'(pdu_octet_mem_addr) > max_addr) max_addr = int'(pdu_octet_mem_addr);
            if (m_valid && m_ready) begin
                rx_q.push_back({m_last, m_data});
                last_xfer_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_head  = {m_last, m_data};
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        decode_end = 1'b0;
        m_ready    = rdy_toggle ? rdy_pat[pidx % 4] : rdy_const;
        pidx++;
    endtask

    task automatic send(input int plen, input bit crc, input int phase);
        payload_length  = 7'(plen);
        crc_ok          = crc;
        best_phase      = 3'(phase);
        decode_end      = 1'b1;
        t_de            = cyc;
        base            = rx_q.size();
        first_valid_cyc = -1;
        last_xfer_cyc   = -1;
        max_addr        = 0;
        tick();
    endtask

    // A decode_end that must be rejected because a packet is in progress
    task automatic pulse_drop(input int plen);
        payload_length = 7'(plen);
        crc_ok         = 1'b1;
        decode_end     = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        for (n = 0; n < budget && (busy || m_valid); n++) tick();
        chk("idle_timeout", 32'(busy || m_valid), 32'd0);
    endtask

    task automatic check_octets(input string tag, input int n);
        int got;
        got = rx_q.size() - base;
        chk({tag, "_count"}, 32'(got), 32'(n));
        for (int i = 0; i < n && base + i < rx_q.size(); i++) begin
            chk({tag, "_octet"}, 32'(rx_q[base + i]), {23'd0, (i == n - 1), 8'(i)});
        end
        $display("pkt %s: %0d octets received, num=%0d trunc=%0d drop=%0d",
                 tag, got, pkt_num_octet, pkt_truncated, drop_count);
    endtask

    initial begin
        int sc;
        for (int i = 0; i < 64; i++) ram[i] = 8'(i);
        rst_n          = 1'b0;
        decode_end     = 1'b0;
        crc_ok         = 1'b0;
        best_phase     = '0;
        payload_length = '0;
        m_ready        = 1'b1;
        first_valid_cyc = -1;
        repeat (3) tick();

        // Reset state
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_status", 32'(pkt_status_valid), 0);
        chk("rst_num", 32'(pkt_num_octet), 0);
        chk("rst_addr", 32'(pdu_octet_mem_addr), 0);
        rst_n = 1'b1;
        tick();

        // Basic packet, m_ready held high: 7 octets, exact latency
        sc = status_cnt;
        send(5, 1'b1, 3);
        wait_idle(100);
        chk("t1_status_cyc", 32'(status_cyc - t_de), 1);
        chk("t1_status_cnt", 32'(status_cnt - sc), 1);
        chk("t1_first_valid", 32'(first_valid_cyc - t_de), 3);
        chk("t1_last_xfer", 32'(last_xfer_cyc - t_de), 9);
        chk("t1_num", 32'(pkt_num_octet), 7);
        chk("t1_phase", 32'(pkt_best_phase), 3);
        chk("t1_crc", 32'(pkt_crc_ok), 1);
        chk("t1_trunc", 32'(pkt_truncated), 0);
        chk("t1_max_addr", 32'(max_addr), 6);
        chk("t1_addr_idle", 32'(pdu_octet_mem_addr), 0);
        check_octets("t1", 7);

        // Same packet with ready toggling 1,0,0,1
        rdy_toggle = 1'b1;
        pidx       = 0;
        send(5, 1'b1, 3);
        wait_idle(200);
        check_octets("t2", 7);
        rdy_toggle = 1'b0;

        // Oversize payload is clamped to 64 octets
        send(100, 1'b1, 2);
        wait_idle(300);
        chk("t3_num", 32'(pkt_num_octet), 64);
        chk("t3_trunc", 32'(pkt_truncated), 1);
        chk("t3_phase", 32'(pkt_best_phase), 2);
        chk("t3_max_addr", 32'(max_addr), 63);
        check_octets("t3", 64);

        // Overrun: second decode_end 4 cycles after the first, stream stalled
        rdy_const = 1'b0;
        sc = status_cnt;
        send(5, 1'b1, 3);
        repeat (3) tick();
        pulse_drop(20);
        tick();
        chk("t4_drop", 32'(drop_count), 1);
        chk("t4_num_held", 32'(pkt_num_octet), 7);
        chk("t4_status_cnt", 32'(status_cnt - sc), 1);
        rdy_const = 1'b1;
        wait_idle(200);
        check_octets("t4", 7);

        // payload_length=0 with a decode_end on the final transfer cycle
        sc = status_cnt;
        send(0, 1'b1, 1);
        while (cyc < t_de + 4) tick();
        pulse_drop(9);
        wait_idle(50);
        repeat (3) tick();
        chk("t5_last_xfer", 32'(last_xfer_cyc - t_de), 4);
        chk("t5_drop", 32'(drop_count), 2);
        chk("t5_status_cnt", 32'(status_cnt - sc), 1);
        chk("t5_num", 32'(pkt_num_octet), 2);
        chk("t5_busy", 32'(busy), 0);
        check_octets("t5", 2);

        // Drop counter saturation
        rdy_const = 1'b0;
        send(5, 1'b1, 0);
        for (int i = 0; i < 300; i++) begin
            pulse_drop(20);
            tick();
            if (i == 99) chk("t6_drop_100", 32'(drop_count), 102);
        end
        chk("t6_drop_sat", 32'(drop_count), 255);
        rdy_const = 1'b1;
        wait_idle(200);
        check_octets("t6", 7);

        // Reset in the middle of a packet
        send(20, 1'b1, 5);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("t7_m_valid", 32'(m_valid), 0);
        chk("t7_m_last", 32'(m_last), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_drop", 32'(drop_count), 0);
        chk("t7_num", 32'(pkt_num_octet), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        base  = rx_q.size();
        repeat (40) tick();
        chk("t7_no_octets", 32'(rx_q.size() - base), 0);
        $display("pkt t7: reset mid-packet, %0d octets after reset", rx_q.size() - base);

        // crc_ok=0 handling
        sc = status_cnt;
        send(5, 1'b0, 4);
`ifdef BTLE_RX_PDU_FETCH_CRC_FILTER_EN
        chk("t8_busy", 32'(busy), 0);
        repeat (12) tick();
        chk("t8_status_cnt", 32'(status_cnt - sc), 1);
        chk("t8_crc", 32'(pkt_crc_ok), 0);
        chk("t8_phase", 32'(pkt_best_phase), 4);
        chk("t8_first_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
        check_octets("t8_bad", 0);
        send(5, 1'b1, 5);
        wait_idle(100);
        chk("t8_crc_good", 32'(pkt_crc_ok), 1);
        check_octets("t8_good", 7);
`else
        wait_idle(100);
        chk("t8_status_cnt", 32'(status_cnt - sc), 1);
        chk("t8_crc", 32'(pkt_crc_ok), 0);
        chk("t8_phase", 32'(pkt_best_phase), 4);
        check_octets("t8", 7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/btle_rx_pdu_fetch.md
Name: btle_rx_pdu_fetch

Overview:
- Unloads one decoded PDU from the btle_rx octet RAM read port after each decode_end.
- Emits the octets as a backpressured byte stream (valid/ready/last), with per-packet status: crc_ok, best_phase, octet count, truncation.
- Sits between btle_rx and the host/DMA side, in place of ad-hoc read sequencing.
- Generalises the read-out with configurable address/length widths, a FIFO decoupling RAM latency from downstream stalls, and overrun accounting.

Parameters:
- PDU_ADDR_WIDTH, 6, width of pdu_octet_mem_addr; max octets per packet = 2^PDU_ADDR_WIDTH.
- PAYLOAD_LENGTH_BIT_WIDTH, 7, width of payload_length.
- BEST_PHASE_BIT_WIDTH, 3, width of best_phase.
- FIFO_DEPTH_LOG2, 2, output FIFO depth = 2^FIFO_DEPTH_LOG2 octets (min 1, i.e. depth 2).
- DROP_COUNT_BIT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock (16 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- decode_end  in  1  one-cycle pulse from btle_rx: PDU complete in RAM
- crc_ok  in  1  CRC result, valid with decode_end
- best_phase  in  BEST_PHASE_BIT_WIDTH  valid with decode_end
- payload_length  in  PAYLOAD_LENGTH_BIT_WIDTH  valid with decode_end
- pdu_octet_mem_addr  out  PDU_ADDR_WIDTH  RAM read address
- pdu_octet_mem_data  in  8  RAM read data, 1-cycle registered read latency
- m_data  out  8  stream octet
- m_valid  out  1  stream valid
- m_last  out  1  marks the final octet of the packet
- m_ready  in  1  downstream ready
- pkt_status_valid  out  1  one-cycle pulse when the packet is latched
- pkt_crc_ok  out  1  latched crc_ok
- pkt_best_phase  out  BEST_PHASE_BIT_WIDTH  latched best_phase
- pkt_num_octet  out  PDU_ADDR_WIDTH+1  octets the packet will emit
- pkt_truncated  out  1  length was clamped
- busy  out  1  state != IDLE
- drop_count  out  DROP_COUNT_BIT_WIDTH  packets dropped due to overrun, saturating

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; drop_count 0.
- FSM has three states: IDLE, FETCH, DRAIN.
- IDLE with decode_end:
  - Latch status and compute N = payload_length + 2 (header 2 octets plus payload), width PAYLOAD_LENGTH_BIT_WIDTH+1.
  - If N > 2^PDU_ADDR_WIDTH: clamp N to 2^PDU_ADDR_WIDTH and set pkt_truncated=1; otherwise pkt_truncated=0.
  - pkt_status_valid pulses the next cycle. Go to FETCH. Reset read address to 0.
- FETCH issues addresses 0..N-1, one per cycle, only when (FIFO occupancy + reads in flight) < depth. Reads in flight is at most 1.
  - Returned data is pushed into the FIFO on the cycle after issue.
  - After address N-1 is issued, go to DRAIN.
- DRAIN: wait until the octet tagged last leaves the FIFO (m_valid && m_ready), then go to IDLE.
- Stream rules:
  - m_valid = FIFO non-empty. m_data/m_last are the FIFO head.
  - Transfer occurs when m_valid && m_ready.
  - Once asserted, m_valid/m_data/m_last hold until transfer.
- Latency: with m_ready=1, the first octet appears on m_valid 3 cycles after decode_end. N octets complete by decode_end + N + 2.
- Address wrap: pdu_octet_mem_addr never exceeds N-1. It holds its last value when not issuing and returns to 0 on IDLE entry.
- decode_end while busy=1, including the same cycle as the final transfer:
  - The packet is dropped and drop_count increments, saturating at all-ones.
  - The in-progress packet continues unaffected.
- pkt_* outputs hold until the next accepted packet.
- Reset asserted mid-packet: immediate return to reset values. A partial packet is abandoned; m_last is never emitted for it.
- N=2 (payload_length=0): exactly 2 octets; m_last on the second.

Optional Feature:
- Macro BTLE_RX_PDU_FETCH_CRC_FILTER_EN.
- When defined:
  - A packet with crc_ok=0 is consumed silently: no stream output, no FETCH, and pkt_status_valid still pulses with pkt_crc_ok=0.
  - A separate drop_count is not incremented.
  - busy stays 0.
- When undefined: all packets are streamed regardless of crc_ok.

Test Plan:
- RAM preloaded 0x00..0x3F; decode_end with payload_length=5, crc_ok=1, best_phase=3, m_ready=1 → m_data 00,01,02,03,04,05,06; m_last on 06; pkt_num_octet=7; pkt_status_valid pulse; first m_valid at decode_end+3.
- Same packet with m_ready toggling 1,0,0,1 repeatedly → identical 7-octet sequence; no duplicates or losses; m_data stable while stalled.
- payload_length=100 (N=102 > 64) → 64 octets 00..3F emitted, pkt_truncated=1, pkt_num_octet=64.
- Second decode_end 4 cycles after the first (payload_length=20, m_ready=0) → drop_count=1; first packet intact. Repeat 300 times → drop_count saturates at 255.
- payload_length=0 → 2 octets, m_last on the second. Then assert rst_n=0 mid-packet → m_valid=0, busy=0, drop_count=0 immediately.
- With BTLE_RX_PDU_FETCH_CRC_FILTER_EN defined: crc_ok=0 packet → no m_valid, pkt_crc_ok=0 pulse; a following crc_ok=1 packet streams normally.
